// File: rtl/block_acc_pkg.sv
// Purpose : shared types, mode encodings and width helpers for block_accumulator.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package block_acc_pkg;

    // Per-block result mode, sampled on the cycle a full block completes.
    localparam logic MODE_SUM = 1'b0;
    localparam logic MODE_AVG = 1'b1;

    // Output-stage state: S_HOLD while a result sits in the output register.
    typedef enum logic {
        S_ACC  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    // Result width: a full block of the most negative sample needs exactly
    // log2(block_len) extra bits, so the sum can never overflow.
    function automatic int acc_width(input int data_w, input int block_len);
        return data_w + $clog2(block_len);
    endfunction

    // Sample-count width: must hold block_len itself (1..block_len).
    function automatic int cnt_width(input int block_len);
        return $clog2(block_len) + 1;
    endfunction

endpackage

// File: rtl/block_accumulator_if.sv
// Purpose : input/output valid-ready streams of block_accumulator, named from the DUT's side.
// Latency : n/a (wiring only).
// Backpressure: o_ready stalls the input stream; i_ready stalls the result stream.
// Ports   : i_valid/i_x/i_flush/i_mode/o_ready  - sample stream into the accumulator
//           o_valid/o_acc/o_count/i_ready       - result stream out of the accumulator
interface block_accumulator_if
    import block_acc_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BLOCK_LEN = 16
);
    localparam int ACC_W = acc_width(DATA_W, BLOCK_LEN);
    localparam int CNT_W = cnt_width(BLOCK_LEN);

    logic                     i_valid;
    logic                     o_ready;
    logic signed [DATA_W-1:0] i_x;
    logic                     i_flush;
    logic                     i_mode;

    logic                     o_valid;
    logic                     i_ready;
    logic signed [ACC_W-1:0]  o_acc;
    logic        [CNT_W-1:0]  o_count;

    // DUT side.
    modport slave (
        input  i_valid, i_x, i_flush, i_mode, i_ready,
        output o_ready, o_valid, o_acc, o_count
    );

    // Upstream producer / downstream consumer side.
    modport master (
        output i_valid, i_x, i_flush, i_mode, i_ready,
        input  o_ready, o_valid, o_acc, o_count
    );

endinterface

// File: rtl/block_acc_out_stage.sv
// Purpose : one-deep result holding register with valid/ready and upstream ready generation.
// Latency : 1 cycle from i_load to o_valid.
// Backpressure: o_ready drops while a result is held and i_ready is low; all outputs freeze.
// Ports   : i_clk, i_rst_n (async, active-low)
//           i_load, i_acc, i_count   - new result from the accumulator (only when o_ready=1)
//           i_ready                  - downstream ready
//           o_valid, o_acc, o_count  - registered result stream
//           o_ready                  - upstream may advance this cycle
module block_acc_out_stage
    import block_acc_pkg::*;
#(
    parameter int ACC_W = 12,
    parameter int CNT_W = 5
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_load,
    input  logic signed [ACC_W-1:0] i_acc,
    input  logic        [CNT_W-1:0] i_count,
    input  logic                    i_ready,
    output logic                    o_valid,
    output logic                    o_ready,
    output logic signed [ACC_W-1:0] o_acc,
    output logic        [CNT_W-1:0] o_count
);

    state_t                  r_state;
    logic signed [ACC_W-1:0] r_acc;
    logic        [CNT_W-1:0] r_count;

    // A result is pending exactly while in S_HOLD, so o_valid comes straight
    // off the state register.
    assign o_valid = (r_state == S_HOLD);

    // Register is free if empty or being drained this cycle; this lets a new
    // result load on the same edge the old one is consumed.
    assign o_ready = !(o_valid && !i_ready);

    assign o_acc   = r_acc;
    assign o_count = r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_ACC;
            r_acc   <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_ACC: begin
                    if (i_load) begin
                        r_state <= S_HOLD;
                        r_acc   <= i_acc;
                        r_count <= i_count;
                    end
                end
                S_HOLD: begin
                    if (i_ready) begin
                        // Back-to-back result keeps o_valid high with new data.
                        if (i_load) begin
                            r_acc   <= i_acc;
                            r_count <= i_count;
                        end else begin
                            r_state <= S_ACC;
                        end
                    end
                end
                default: r_state <= S_ACC;
            endcase
        end
    end

endmodule

// File: rtl/block_accumulator.sv
// Purpose : sums BLOCK_LEN signed samples (or a flushed partial block) and emits sum or mean.
// Latency : 1 cycle from the completing sample / flush to o_valid.
// Backpressure: o_ready = !(o_valid && !i_ready); stalled samples and flushes must be held upstream.
// Ports   : i_clk, i_rst_n (async, active-low)
//           bus (slave): i_valid/i_x/i_flush/i_mode/o_ready in, o_valid/o_acc/o_count/i_ready out
module block_accumulator
    import block_acc_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BLOCK_LEN = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    block_accumulator_if.slave  bus
);

    localparam int LOG2_LEN = $clog2(BLOCK_LEN);
    localparam int ACC_W    = acc_width(DATA_W, BLOCK_LEN);
    localparam int CNT_W    = cnt_width(BLOCK_LEN);

    if (DATA_W < 2 || DATA_W > 32 || BLOCK_LEN < 2 || BLOCK_LEN > 256 ||
        (BLOCK_LEN & (BLOCK_LEN - 1)) != 0) begin : g_bad_param
        $error("block_accumulator: DATA_W must be 2..32, BLOCK_LEN a power of 2 in 2..256");
    end

    logic signed [ACC_W-1:0] r_acc;
    logic        [CNT_W-1:0] r_cnt;

    logic                    w_accept;
    logic                    w_flush;
    logic signed [ACC_W-1:0] w_x_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_avg;
    logic signed [ACC_W-1:0] w_res;
    logic        [CNT_W-1:0] w_cnt_next;
    logic                    w_full;
    logic                    w_load;

    assign w_accept = bus.i_valid && bus.o_ready;
    assign w_flush  = bus.i_flush && bus.o_ready;

    assign w_x_ext    = {{(ACC_W - DATA_W){bus.i_x[DATA_W-1]}}, bus.i_x};
    // The same-cycle sample is folded in before any flush decision.
    assign w_sum      = w_accept ? (r_acc + w_x_ext) : r_acc;
    assign w_cnt_next = r_cnt + CNT_W'(w_accept);
    assign w_full     = w_accept && (r_cnt == CNT_W'(BLOCK_LEN - 1));

    // Arithmetic shift floors toward -inf, which is the intended mean.
    assign w_avg = w_sum >>> LOG2_LEN;

    // Partial (flushed) blocks always report the raw sum.
    assign w_res  = (w_full && bus.i_mode == MODE_AVG) ? w_avg : w_sum;
    // A flush with nothing accumulated produces no result.
    assign w_load = w_full || (w_flush && w_cnt_next != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= w_cnt_next;
        end
    end

    // w_cnt_next equals BLOCK_LEN on a full block, so it serves as o_count in both cases.
    block_acc_out_stage #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_out_stage (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_load),
        .i_acc   (w_res),
        .i_count (w_cnt_next),
        .i_ready (bus.i_ready),
        .o_valid (bus.o_valid),
        .o_ready (bus.o_ready),
        .o_acc   (bus.o_acc),
        .o_count (bus.o_count)
    );

endmodule
